// File: rtl/uart_rx_pkg.sv
// uart_rx shared definitions: FSM encoding, legal prescale
// values and the parity_type encoding shared with the transmitter.
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W_DEF-1:0] PRESCALE_32 = 6'd32;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx bit sampler: three samples around mid-bit,
// resolved by 2-of-3 majority into a registered bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  enable_i,
  output logic                  bit_o
);

  logic [PRESCALE_W-1:0] half;
  logic [1:0]            smp_q;
  logic                  bit_q;
  logic                  maj_d;

  assign half  = prescale_i >> 1;
  assign maj_d = (smp_q[0] & smp_q[1]) |
                 (smp_q[0] & rx_i) |
                 (smp_q[1] & rx_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      smp_q <= 2'b11;
      bit_q <= 1'b1;
    end else if (enable_i) begin
      if (edge_cnt_i == half - PRESCALE_W'(1))
        smp_q[0] <= rx_i;
      if (edge_cnt_i == half)
        smp_q[1] <= rx_i;
      // third sample is taken live and voted in the same edge
      if (edge_cnt_i == half + PRESCALE_W'(1))
        bit_q <= maj_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 / 8E1 / 8O1,
// one-cycle Data_Valid strobe, sticky parity/stop flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_error,
  output logic                  stop_error
);

  localparam int BCW = $clog2(DATA_WIDTH);

  rx_state_e             state_q;
  logic [PRESCALE_W-1:0] edge_q;
  logic [PRESCALE_W-1:0] edge_d;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  dv_q;
  logic                  par_err_q;
  logic                  stop_err_q;
  logic                  bit_rx;
  logic                  resolve;
  logic                  bit_end;
  logic                  par_exp;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .rx_i      (RX_IN),
    .edge_cnt_i(edge_q),
    .prescale_i(prescale_q),
    .enable_i  (state_q != ST_IDLE),
    .bit_o     (bit_rx)
  );

  assign resolve = edge_q == (prescale_q >> 1) + PRESCALE_W'(2);
  assign bit_end = edge_q == prescale_q - PRESCALE_W'(1);
  assign edge_d  = bit_end ? '0 : edge_q + PRESCALE_W'(1);
  assign par_exp = (^shift_q) ^ par_type_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      edge_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          edge_q    <= '0;
          bit_cnt_q <= '0;
          if (!RX_IN) begin
            state_q    <= ST_START;
            edge_q     <= PRESCALE_W'(1);
            prescale_q <= Prescale;
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
          end
        end
        ST_START: begin
          edge_q <= edge_d;
          if (resolve && bit_rx) begin
            state_q <= ST_IDLE;
            edge_q  <= '0;
          end else begin
            if (resolve) begin
              par_err_q  <= 1'b0;
              stop_err_q <= 1'b0;
            end
            if (bit_end)
              state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          edge_q <= edge_d;
          if (resolve)
            shift_q <= {bit_rx, shift_q[DATA_WIDTH-1:1]};
          if (bit_end) begin
            if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end
        end
        ST_PARITY: begin
          edge_q <= edge_d;
          if (resolve && (bit_rx != par_exp))
            par_err_q <= 1'b1;
          if (bit_end)
            state_q <= ST_STOP;
        end
        ST_STOP: begin
          edge_q <= edge_d;
          if (resolve && !bit_rx)
            stop_err_q <= 1'b1;
          if (bit_end) begin
            state_q <= ST_IDLE;
            if (!par_err_q && !stop_err_q) begin
              data_q <= shift_q;
              dv_q   <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign P_DATA     = data_q;
  assign Data_Valid = dv_q;
  assign par_error  = par_err_q;
  assign stop_error = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// uart_rx bench: table of directed frames plus hand-written
// glitch, reset and back-to-back sequences.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       parity_enable = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_error;
  logic       stop_error;

  uart_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .par_error    (par_error),
    .stop_error   (stop_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         dv_cnt = 0;
  int         dv_cyc = 0;
  int         dv_prev = 0;
  logic [7:0] dv_data = 8'h00;
  logic [7:0] dv_prev_data = 8'h00;

  always @(negedge CLK) begin
    if (Data_Valid === 1'b1) begin
      dv_prev      = dv_cyc;
      dv_prev_data = dv_data;
      dv_cyc       = cyc;
      dv_data      = P_DATA;
      dv_cnt       = dv_cnt + 1;
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run = n_run + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int p, input logic v,
                           input int gl_edge);
    for (int k = 0; k < p; k++) begin
      RX_IN = (k == gl_edge) ? ~v : v;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input int p, input logic pen,
                            input logic ptype,
                            input logic [7:0] d,
                            input logic pb, input logic sb,
                            input logic [7:0] gl_mask,
                            output int start);
    Prescale      = p[5:0];
    parity_enable = pen;
    parity_type   = ptype;
    start         = cyc;
    drive_bit(p, 1'b0, -1);
    for (int i = 0; i < 8; i++)
      drive_bit(p, d[i], gl_mask[i] ? p / 2 : -1);
    if (pen)
      drive_bit(p, pb, -1);
    drive_bit(p, sb, -1);
    RX_IN = 1'b1;
  endtask

  typedef struct {
    int         p;
    logic       pen;
    logic       ptype;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic       exp_dv;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_stop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int start;
    int s0;
    int s1;
    int base;

    vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{8,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{16, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[7] = '{16, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0};
    vecs[8] = '{8,  1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};

    repeat (3) @(posedge CLK);
    #1;
    check("rst_pdata", P_DATA, 0);
    check("rst_dv", Data_Valid, 0);
    check("rst_par", par_error, 0);
    check("rst_stop", stop_error, 0);
    RST = 1'b1;
    idle(5);

    for (int i = 0; i < 9; i++) begin
      base = dv_cnt;
      send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptype, vecs[i].d,
                 vecs[i].pb, vecs[i].sb, 8'h00, start);
      idle(4);
      check($sformatf("v%0d_strobes", i), dv_cnt - base,
            vecs[i].exp_dv ? 1 : 0);
      if (vecs[i].exp_dv)
        check($sformatf("v%0d_latency", i), dv_cyc - start,
              (10 + (vecs[i].pen ? 1 : 0)) * vecs[i].p);
      check($sformatf("v%0d_pdata", i), P_DATA, vecs[i].exp_data);
      check($sformatf("v%0d_par", i), par_error, vecs[i].exp_par);
      check($sformatf("v%0d_stop", i), stop_error, vecs[i].exp_stop);
    end

    // 2-cycle start glitch, then a frame with mid-bit glitches
    base = dv_cnt;
    Prescale = 6'd16;
    parity_enable = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    idle(30);
    check("glitch_strobes", dv_cnt - base, 0);
    check("glitch_pdata", P_DATA, 8'hC3);
    check("glitch_par", par_error, 0);
    check("glitch_stop", stop_error, 0);
    send_frame(16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'hFF, start);
    idle(4);
    check("vote_strobes", dv_cnt - base, 1);
    check("vote_latency", dv_cyc - start, 160);
    check("vote_pdata", P_DATA, 8'h5A);

    // reset pulse inside data bit 4 of 0xF3
    base = dv_cnt;
    Prescale = 6'd8;
    parity_enable = 1'b0;
    drive_bit(8, 1'b0, -1);
    drive_bit(8, 1'b1, -1);
    drive_bit(8, 1'b1, -1);
    drive_bit(8, 1'b0, -1);
    drive_bit(8, 1'b0, -1);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check("mrst_pdata", P_DATA, 0);
    check("mrst_dv", Data_Valid, 0);
    check("mrst_par", par_error, 0);
    check("mrst_stop", stop_error, 0);
    idle(60);
    check("mrst_strobes", dv_cnt - base, 0);
    send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 8'h00, start);
    idle(4);
    check("post_rst_strobes", dv_cnt - base, 1);
    check("post_rst_latency", dv_cyc - start, 80);
    check("post_rst_pdata", P_DATA, 8'h81);

    // back-to-back frames, no idle gap
    base = dv_cnt;
    send_frame(32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, s0);
    send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, s1);
    idle(4);
    check("b2b_strobes", dv_cnt - base, 2);
    check("b2b_start_gap", s1 - s0, 320);
    check("b2b_first_lat", dv_prev - s0, 320);
    check("b2b_spacing", dv_cyc - dv_prev, 320);
    check("b2b_first_data", dv_prev_data, 8'h00);
    check("b2b_second_data", dv_data, 8'hFF);
    check("b2b_flags", {par_error, stop_error}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
